// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// mem_bus_master
//   Bus initiator for the memory block: single-byte writes and burst reads,
//   owns abus/mbus only while a transaction is in flight.
//   Rev 1.0
// ============================================================================
module mem_bus_master #(
  parameter logic [15:0] ROM_BASE = 16'hE000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [3:0]  cmd_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        err,
  output logic        busy,
  inout  wire  [15:0] abus,
  inout  wire  [7:0]  mbus,
  output logic        outn,
  output logic        writen
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_ADDR   = 3'd4,
    R_SAMPLE = 3'd5,
    TURN     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic        w_refuse;
  logic        w_load;
  logic        w_outn_n;
  logic        w_writen_n;
  logic        w_abus_oe_n;
  logic        w_mbus_oe_n;

  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic [3:0]  r_count;
  logic        r_abus_oe;
  logic        r_mbus_oe;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_outn;
  logic        r_writen;
  logic        r_err;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;

  always_comb begin
    w_state_n = r_state;
    w_refuse  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_write) begin
            w_state_n = R_ADDR;
          end else if (cmd_addr < ROM_BASE) begin
            w_state_n = W_SETUP;
          end else begin
            w_refuse = 1'b1;
          end
        end
      end
      W_SETUP:  w_state_n = W_STROBE;
      W_STROBE: w_state_n = W_HOLD;
      W_HOLD:   w_state_n = TURN;
      R_ADDR:   w_state_n = R_SAMPLE;
      R_SAMPLE: w_state_n = (r_count != 4'd0) ? R_ADDR : TURN;
      TURN:     w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase

    // Strobes and bus enables are decoded from the next state and registered,
    // so the two strobes and the mbus driver can never overlap.
    w_load      = (r_state == IDLE) && (w_state_n != IDLE);
    w_outn_n    = !((w_state_n == R_ADDR) || (w_state_n == R_SAMPLE));
    w_writen_n  = !(w_state_n == W_STROBE);
    w_mbus_oe_n = (w_state_n == W_SETUP) || (w_state_n == W_STROBE) ||
                  (w_state_n == W_HOLD);
    w_abus_oe_n = w_mbus_oe_n || !w_outn_n;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_addr      <= 16'h0000;
      r_data      <= 8'h00;
      r_count     <= 4'd0;
      r_abus_oe   <= 1'b0;
      r_mbus_oe   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_outn      <= 1'b1;
      r_writen    <= 1'b1;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_state     <= w_state_n;
      r_abus_oe   <= w_abus_oe_n;
      r_mbus_oe   <= w_mbus_oe_n;
      r_cmd_ready <= (w_state_n == IDLE);
      r_busy      <= (w_state_n != IDLE);
      r_outn      <= w_outn_n;
      r_writen    <= w_writen_n;
      r_err       <= w_refuse;
      r_rsp_valid <= (r_state == R_SAMPLE);

      if (w_load) begin
        r_addr  <= cmd_addr;
        r_data  <= cmd_data;
        r_count <= cmd_write ? 4'd0 : cmd_len;
      end

      if (r_state == R_SAMPLE) begin
        r_rsp_data <= mbus;
        if (r_count != 4'd0) begin
          r_addr  <= r_addr + 16'd1;
          r_count <= r_count - 4'd1;
        end
      end
    end
  end

  assign abus      = r_abus_oe ? r_addr : 16'bz;
  assign mbus      = r_mbus_oe ? r_data : 8'bz;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign outn      = r_outn;
  assign writen    = r_writen;
  assign err       = r_err;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_master
//   Memory model with weak bus pulls and a read-data scoreboard.
//   Rev 1.0
// ============================================================================
module tb_mem_bus_master;

  localparam logic [15:0] c_rom_base  = 16'hE000;
  localparam logic [15:0] c_abus_pull = 16'hE000;
  localparam logic [7:0]  c_mbus_pull = 8'hC3;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr  = 16'h0000;
  logic [7:0]  cmd_data  = 8'h00;
  logic [3:0]  cmd_len   = 4'd0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        err;
  logic        busy;
  logic        outn;
  logic        writen;
  wire  [15:0] abus;
  wire  [7:0]  mbus;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  exp_q   [$];

  int n_checks = 0;
  int n_pass   = 0;
  int wlow_cnt = 0;
  int rsp_cnt  = 0;
  int err_cnt  = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  mem_bus_master #(.ROM_BASE(c_rom_base)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err       (err),
    .busy      (busy),
    .abus      (abus),
    .mbus      (mbus),
    .outn      (outn),
    .writen    (writen)
  );

  // External pulls make a released bus read back as a known pattern.
  assign (weak0, weak1) abus = c_abus_pull;
  assign (weak0, weak1) mbus = c_mbus_pull;
  assign mbus = outn ? 8'bz : mem[abus];

  always @(posedge clk) begin
    if (!writen && (abus < c_rom_base)) mem[abus] <= mbus;
  end

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hC7;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin : b_mon
    logic [7:0] e;
    if (mon_en) begin
      if (!writen) wlow_cnt++;
      if (err) err_cnt++;
      check("strobe_excl", 32'(!outn && !writen), 32'd0);
      check("ready_idle", 32'(cmd_ready), 32'(!busy));
      if (!busy) begin
        check("abus_rel", 32'(abus), 32'(c_abus_pull));
        check("mbus_rel", 32'(mbus), 32'(c_mbus_pull));
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          check("rsp_extra", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e));
        end
      end
    end
  end

  // Presents a command (cmd_valid left high) and returns at the accepting edge.
  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d,
                       input logic [3:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = l;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    if (!w) begin
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[16'(int'(a) + i)]);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    issue(1'b1, a, d, 4'd0);
    if (a < c_rom_base) ref_mem[a] = d;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ready"},  32'(cmd_ready), 32'd1);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_outn"},   32'(outn),      32'd1);
    check({tag, "_writen"}, 32'(writen),    32'd1);
    check({tag, "_rspv"},   32'(rsp_valid), 32'd0);
    check({tag, "_err"},    32'(err),       32'd0);
    check({tag, "_rspd"},   32'(rsp_data),  32'd0);
    check({tag, "_abus"},   32'(abus),      32'(c_abus_pull));
    check({tag, "_mbus"},   32'(mbus),      32'(c_mbus_pull));
  endtask

  initial begin
    logic [4:0] seq_w, seq_rdy;
    logic [3:0] seq_rv, seq_busy;
    logic [1:0] seq_err, seq_eb;
    int wl0, c0, e0, n;

    for (int a = 0; a < 65536; a++) begin
      mem[a]     = init_byte(16'(a));
      ref_mem[a] = init_byte(16'(a));
    end

    repeat (3) @(negedge clk);
    check_rst("rst0");
    resetn = 1'b1;
    mon_en = 1'b1;

    // Write then read with cycle-level timing
    wl0 = wlow_cnt;
    wr(16'h0004, 8'hA5);
    seq_w = '0; seq_rdy = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
      seq_w   = {seq_w[3:0], writen};
      seq_rdy = {seq_rdy[3:0], cmd_ready};
    end
    check("wr_writen_seq", 32'(seq_w), 32'(5'b10111));
    check("wr_ready_seq", 32'(seq_rdy), 32'(5'b00001));
    check("wr_strobe_cnt", 32'(wlow_cnt - wl0), 32'd1);

    c0 = rsp_cnt;
    issue(1'b0, 16'h0004, 8'h00, 4'd0);
    seq_rv = '0; seq_busy = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
      seq_rv   = {seq_rv[2:0], rsp_valid};
      seq_busy = {seq_busy[2:0], busy};
    end
    check("rd_rspv_seq", 32'(seq_rv), 32'(4'b0010));
    check("rd_busy_seq", 32'(seq_busy), 32'(4'b1110));
    check("rd_pulses", 32'(rsp_cnt - c0), 32'd1);
    check("rd_a5", 32'(rsp_data), 32'hA5);

    // ROM protection
    wl0 = wlow_cnt; e0 = err_cnt;
    wr(16'hE007, 8'h11);
    seq_err = '0; seq_eb = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
      seq_err = {seq_err[0], err};
      seq_eb  = {seq_eb[0], busy};
    end
    check("rom_err_seq", 32'(seq_err), 32'(2'b10));
    check("rom_busy_seq", 32'(seq_eb), 32'd0);
    check("rom_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("rom_no_strobe", 32'(wlow_cnt - wl0), 32'd0);
    issue(1'b0, 16'hE007, 8'h00, 4'd0);
    wait_idle("rom_rd_done");
    check("rom_c0", 32'(rsp_data), 32'hC0);

    // Burst crossing the top of the address space
    wr(16'h8004, 8'hB6);
    wr(16'h0000, 8'h5A);
    c0 = rsp_cnt;
    issue(1'b0, 16'hFFFF, 8'h00, 4'd1);
    wait_idle("wrap_done");
    check("wrap_pulses", 32'(rsp_cnt - c0), 32'd2);
    check("wrap_last", 32'(rsp_data), 32'h5A);

    // Back-to-back with cmd_valid held
    wl0 = wlow_cnt; c0 = rsp_cnt;
    for (int i = 0; i < 4; i++) wr(16'(16'h0200 + i), 8'(8'h10 + 8'(i * 7)));
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(16'h0200 + i), 8'h00, 4'd0);
    wait_idle("b2b_done");
    check("b2b_writes", 32'(wlow_cnt - wl0), 32'd4);
    check("b2b_reads", 32'(rsp_cnt - c0), 32'd4);

    // Reset during W_SETUP
    wl0 = wlow_cnt;
    issue(1'b1, 16'h0010, 8'h77, 4'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    resetn    = 1'b0;
    @(negedge clk);
    check_rst("rstw");
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_no_strobe", 32'(wlow_cnt - wl0), 32'd0);
    check("rstw_mem", 32'(mem[16'h0010]), 32'(ref_mem[16'h0010]));
    issue(1'b0, 16'h0010, 8'h00, 4'd0);
    wait_idle("rstw_rd_done");

    // Reset part-way through a 16-byte burst
    c0 = rsp_cnt;
    issue(1'b0, 16'h0100, 8'h00, 4'hF);
    n = 0;
    while ((rsp_cnt - c0) < 5 && n < 100) begin
      @(negedge clk);
      if (n == 0) cmd_valid = 1'b0;
      n++;
    end
    check("rstb_progress", 32'(rsp_cnt - c0), 32'd5);
    resetn = 1'b0;
    @(negedge clk);
    check_rst("rstb");
    exp_q.delete();
    resetn = 1'b1;
    c0 = rsp_cnt;
    repeat (40) @(negedge clk);
    check("rstb_quiet", 32'(rsp_cnt - c0), 32'd0);

    // Recovery read after reset
    c0 = rsp_cnt;
    issue(1'b0, 16'h0102, 8'h00, 4'd2);
    wait_idle("recov_done");
    check("recov_pulses", 32'(rsp_cnt - c0), 32'd3);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
